// File: rtl/rv_pkg.sv
// RV32I encoding constants, decoded command codes and immediate formats
// shared by the decoder, the decode stage and its testbench.
package rv_pkg;

    // Major opcodes
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_ALUI   = 7'b0010011;
    localparam logic [6:0] OPC_ALU    = 7'b0110011;

    // Branch funct3
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Load/store funct3
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // ALU funct3 (shared by register and immediate forms)
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    // funct7
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam int CMD_W = 6;

    typedef enum logic [CMD_W-1:0] {
        CMD_NOP   = 6'd0,
        CMD_LUI   = 6'd1,
        CMD_AUIPC = 6'd2,
        CMD_JAL   = 6'd3,
        CMD_JALR  = 6'd4,
        CMD_BEQ   = 6'd5,
        CMD_BNE   = 6'd6,
        CMD_BLT   = 6'd7,
        CMD_BGE   = 6'd8,
        CMD_BLTU  = 6'd9,
        CMD_BGEU  = 6'd10,
        CMD_LB    = 6'd11,
        CMD_LH    = 6'd12,
        CMD_LW    = 6'd13,
        CMD_LBU   = 6'd14,
        CMD_LHU   = 6'd15,
        CMD_SB    = 6'd16,
        CMD_SH    = 6'd17,
        CMD_SW    = 6'd18,
        CMD_ADDI  = 6'd19,
        CMD_SLTI  = 6'd20,
        CMD_SLTIU = 6'd21,
        CMD_XORI  = 6'd22,
        CMD_ORI   = 6'd23,
        CMD_ANDI  = 6'd24,
        CMD_SLLI  = 6'd25,
        CMD_SRLI  = 6'd26,
        CMD_SRAI  = 6'd27,
        CMD_ADD   = 6'd28,
        CMD_SUB   = 6'd29,
        CMD_SLL   = 6'd30,
        CMD_SLT   = 6'd31,
        CMD_SLTU  = 6'd32,
        CMD_XOR   = 6'd33,
        CMD_SRL   = 6'd34,
        CMD_SRA   = 6'd35,
        CMD_OR    = 6'd36,
        CMD_AND   = 6'd37
    } cmd_e;

    // SHAMT is the zero-extended 5-bit shift amount of SLLI/SRLI/SRAI
    typedef enum logic [2:0] {
        IMM_NONE  = 3'd0,
        IMM_I     = 3'd1,
        IMM_S     = 3'd2,
        IMM_B     = 3'd3,
        IMM_U     = 3'd4,
        IMM_J     = 3'd5,
        IMM_SHAMT = 3'd6
    } imm_fmt_e;

endpackage

// File: rtl/rv_decoder.sv
// Purely combinational RV32I decoder: instruction word -> command, immediate,
// source/destination register fields and legality. Illegal encodings decode
// as a NOP with no register reads and no write-back.
module rv_decoder
    import rv_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic [31:0]           instr,
    output cmd_e                  cmd,
    output logic [XLEN-1:0]       imm,
    output logic                  rs1_en,
    output logic                  rs2_en,
    output logic [REG_ADDR_W-1:0] rs1_addr,
    output logic [REG_ADDR_W-1:0] rs2_addr,
    output logic [REG_ADDR_W-1:0] rd,
    output logic                  rd_we,
    output logic                  illegal
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd_field;
    cmd_e        cmd_next;
    imm_fmt_e    fmt_next;
    logic        use_rs1;
    logic        use_rs2;
    logic        writes_rd;
    logic        bad;
    logic [31:0] imm32;

    assign opcode   = instr[6:0];
    assign funct3   = instr[14:12];
    assign funct7   = instr[31:25];
    assign rd_field = instr[11:7];

    // Classify the opcode and pick command, immediate format and register usage
    always_comb begin
        cmd_next  = CMD_NOP;
        fmt_next  = IMM_NONE;
        use_rs1   = 1'b0;
        use_rs2   = 1'b0;
        writes_rd = 1'b0;
        bad       = 1'b0;
        case (opcode)
            OPC_LUI: begin
                cmd_next  = CMD_LUI;
                fmt_next  = IMM_U;
                writes_rd = 1'b1;
            end
            OPC_AUIPC: begin
                cmd_next  = CMD_AUIPC;
                fmt_next  = IMM_U;
                writes_rd = 1'b1;
            end
            OPC_JAL: begin
                cmd_next  = CMD_JAL;
                fmt_next  = IMM_J;
                writes_rd = 1'b1;
            end
            OPC_JALR: begin
                cmd_next  = CMD_JALR;
                fmt_next  = IMM_I;
                use_rs1   = 1'b1;
                writes_rd = 1'b1;
                bad       = (funct3 != 3'b000);
            end
            OPC_BRANCH: begin
                fmt_next = IMM_B;
                use_rs1  = 1'b1;
                use_rs2  = 1'b1;
                case (funct3)
                    F3_BEQ:  cmd_next = CMD_BEQ;
                    F3_BNE:  cmd_next = CMD_BNE;
                    F3_BLT:  cmd_next = CMD_BLT;
                    F3_BGE:  cmd_next = CMD_BGE;
                    F3_BLTU: cmd_next = CMD_BLTU;
                    F3_BGEU: cmd_next = CMD_BGEU;
                    default: bad      = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                fmt_next  = IMM_I;
                use_rs1   = 1'b1;
                writes_rd = 1'b1;
                case (funct3)
                    F3_LB:   cmd_next = CMD_LB;
                    F3_LH:   cmd_next = CMD_LH;
                    F3_LW:   cmd_next = CMD_LW;
                    F3_LBU:  cmd_next = CMD_LBU;
                    F3_LHU:  cmd_next = CMD_LHU;
                    default: bad      = 1'b1;
                endcase
            end
            OPC_STORE: begin
                fmt_next = IMM_S;
                use_rs1  = 1'b1;
                use_rs2  = 1'b1;
                case (funct3)
                    F3_LB:   cmd_next = CMD_SB;
                    F3_LH:   cmd_next = CMD_SH;
                    F3_LW:   cmd_next = CMD_SW;
                    default: bad      = 1'b1;
                endcase
            end
            OPC_ALUI: begin
                fmt_next  = IMM_I;
                use_rs1   = 1'b1;
                writes_rd = 1'b1;
                case (funct3)
                    F3_ADD:  cmd_next = CMD_ADDI;
                    F3_SLT:  cmd_next = CMD_SLTI;
                    F3_SLTU: cmd_next = CMD_SLTIU;
                    F3_XOR:  cmd_next = CMD_XORI;
                    F3_OR:   cmd_next = CMD_ORI;
                    F3_AND:  cmd_next = CMD_ANDI;
                    F3_SLL: begin
                        fmt_next = IMM_SHAMT;
                        if (funct7 == F7_BASE) cmd_next = CMD_SLLI;
                        else                   bad      = 1'b1;
                    end
                    default: begin
                        // F3_SR: funct7 selects logical vs arithmetic shift
                        fmt_next = IMM_SHAMT;
                        if (funct7 == F7_BASE)     cmd_next = CMD_SRLI;
                        else if (funct7 == F7_ALT) cmd_next = CMD_SRAI;
                        else                       bad      = 1'b1;
                    end
                endcase
            end
            OPC_ALU: begin
                use_rs1   = 1'b1;
                use_rs2   = 1'b1;
                writes_rd = 1'b1;
                if (funct7 == F7_BASE) begin
                    case (funct3)
                        F3_ADD:  cmd_next = CMD_ADD;
                        F3_SLL:  cmd_next = CMD_SLL;
                        F3_SLT:  cmd_next = CMD_SLT;
                        F3_SLTU: cmd_next = CMD_SLTU;
                        F3_XOR:  cmd_next = CMD_XOR;
                        F3_SR:   cmd_next = CMD_SRL;
                        F3_OR:   cmd_next = CMD_OR;
                        default: cmd_next = CMD_AND;
                    endcase
                end else if (funct7 == F7_ALT) begin
                    case (funct3)
                        F3_ADD:  cmd_next = CMD_SUB;
                        F3_SR:   cmd_next = CMD_SRA;
                        default: bad      = 1'b1;
                    endcase
                end else begin
                    bad = 1'b1;
                end
            end
            default: bad = 1'b1;
        endcase
        // An illegal encoding must not read, write or carry an immediate
        if (bad) begin
            cmd_next  = CMD_NOP;
            fmt_next  = IMM_NONE;
            use_rs1   = 1'b0;
            use_rs2   = 1'b0;
            writes_rd = 1'b0;
        end
    end

    // Assemble the 32-bit immediate for the selected format
    always_comb begin
        imm32 = 32'd0;
        case (fmt_next)
            IMM_I:     imm32 = {{20{instr[31]}}, instr[31:20]};
            IMM_S:     imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:     imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:     imm32 = {instr[31:12], 12'd0};
            IMM_J:     imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            IMM_SHAMT: imm32 = {27'd0, instr[24:20]};
            default:   imm32 = 32'd0;
        endcase
    end

    assign cmd      = cmd_next;
    assign imm      = XLEN'($signed(imm32));
    assign rs1_en   = use_rs1;
    assign rs2_en   = use_rs2;
    assign rs1_addr = use_rs1 ? REG_ADDR_W'(instr[19:15]) : '0;
    assign rs2_addr = use_rs2 ? REG_ADDR_W'(instr[24:20]) : '0;
    assign rd       = writes_rd ? REG_ADDR_W'(rd_field) : '0;
    assign rd_we    = writes_rd & (rd_field != 5'd0);
    assign illegal  = bad;

endmodule

// File: rtl/id_fwd_stage.sv
// Registered RV32I decode stage: decodes, resolves operands through a
// priority forwarding network, stalls on pending producers and holds the
// ID/EX pipeline register behind valid/ready handshakes.
module id_fwd_stage
    import rv_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int NUM_FWD     = 2,
    parameter int REG_ADDR_W  = 5,
    parameter int CMD_W       = 6,
    parameter int STALL_CNT_W = 16
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          flush_in,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [XLEN-1:0]               in_pc,
    input  logic [31:0]                   in_instr,
    output logic                          rs1_rd_en,
    output logic                          rs2_rd_en,
    output logic [REG_ADDR_W-1:0]         rs1_addr,
    output logic [REG_ADDR_W-1:0]         rs2_addr,
    input  logic [XLEN-1:0]               rs1_data,
    input  logic [XLEN-1:0]               rs2_data,
    input  logic [NUM_FWD-1:0]            fwd_valid,
    input  logic [NUM_FWD-1:0]            fwd_pending,
    input  logic [NUM_FWD*REG_ADDR_W-1:0] fwd_addr,
    input  logic [NUM_FWD*XLEN-1:0]       fwd_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [XLEN-1:0]               out_pc,
    output logic [CMD_W-1:0]              out_cmd,
    output logic [XLEN-1:0]               out_rs1_val,
    output logic [XLEN-1:0]               out_rs2_val,
    output logic [XLEN-1:0]               out_imm,
    output logic [REG_ADDR_W-1:0]         out_rd,
    output logic                          out_rd_we,
    output logic                          out_illegal,
    output logic                          hazard_stall,
    output logic [STALL_CNT_W-1:0]        stall_cnt
);

    genvar gi;

    cmd_e                  dec_cmd;
    logic [XLEN-1:0]       dec_imm;
    logic                  dec_rs1_en;
    logic                  dec_rs2_en;
    logic [REG_ADDR_W-1:0] dec_rs1_addr;
    logic [REG_ADDR_W-1:0] dec_rs2_addr;
    logic [REG_ADDR_W-1:0] dec_rd;
    logic                  dec_rd_we;
    logic                  dec_illegal;

    rv_decoder #(
        .XLEN       (XLEN),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_decoder (
        .instr    (in_instr),
        .cmd      (dec_cmd),
        .imm      (dec_imm),
        .rs1_en   (dec_rs1_en),
        .rs2_en   (dec_rs2_en),
        .rs1_addr (dec_rs1_addr),
        .rs2_addr (dec_rs2_addr),
        .rd       (dec_rd),
        .rd_we    (dec_rd_we),
        .illegal  (dec_illegal)
    );

    assign rs1_rd_en = in_valid & dec_rs1_en;
    assign rs2_rd_en = in_valid & dec_rs2_en;
    assign rs1_addr  = dec_rs1_addr;
    assign rs2_addr  = dec_rs2_addr;

    // Unpack the forwarding channels
    logic [NUM_FWD-1:0][REG_ADDR_W-1:0] ch_addr;
    logic [NUM_FWD-1:0][XLEN-1:0]       ch_data;

    generate
        for (gi = 0; gi < NUM_FWD; gi++) begin : g_ch
            assign ch_addr[gi] = fwd_addr[gi*REG_ADDR_W +: REG_ADDR_W];
            assign ch_data[gi] = fwd_data[gi*XLEN +: XLEN];
        end
    endgenerate

    // Operand 0 is rs1, operand 1 is rs2
    logic [1:0]                  op_en;
    logic [1:0][REG_ADDR_W-1:0]  op_addr;
    logic [1:0][XLEN-1:0]        op_rf;
    logic [1:0][XLEN-1:0]        op_val;
    logic [1:0]                  op_haz;

    assign op_en   = {dec_rs2_en, dec_rs1_en};
    assign op_addr = {dec_rs2_addr, dec_rs1_addr};
    assign op_rf   = {rs2_data, rs1_data};

    generate
        for (gi = 0; gi < 2; gi++) begin : g_op
            logic [XLEN-1:0] val;
            logic            haz;

            // Priority forwarding: scan oldest to youngest so the lowest-index
            // matching channel wins, pending or not
            always_comb begin
                val = op_rf[gi];
                haz = 1'b0;
                for (int i = NUM_FWD - 1; i >= 0; i--) begin
                    if (fwd_valid[i] && (ch_addr[i] == op_addr[gi])) begin
                        val = ch_data[i];
                        haz = fwd_pending[i];
                    end
                end
                if (!op_en[gi] || (op_addr[gi] == '0)) begin
                    val = '0;
                    haz = 1'b0;
                end
            end

            assign op_val[gi] = val;
            assign op_haz[gi] = haz;
        end
    endgenerate

    logic accept;

    assign hazard_stall = in_valid & (|op_haz) & ~flush_in;
    assign in_ready     = ~flush_in & ~hazard_stall & (~out_valid | out_ready);
    assign accept       = in_valid & in_ready;

    logic                   valid_reg;
    logic [XLEN-1:0]        pc_reg;
    logic [CMD_W-1:0]       cmd_reg;
    logic [XLEN-1:0]        rs1_val_reg;
    logic [XLEN-1:0]        rs2_val_reg;
    logic [XLEN-1:0]        imm_reg;
    logic [REG_ADDR_W-1:0]  rd_reg;
    logic                   rd_we_reg;
    logic                   illegal_reg;
    logic [STALL_CNT_W-1:0] stall_cnt_reg;

    // ID/EX valid: flush beats accept beats drain; otherwise hold
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            valid_reg <= 1'b0;
        end else if (flush_in) begin
            valid_reg <= 1'b0;
        end else if (accept) begin
            valid_reg <= 1'b1;
        end else if (out_ready) begin
            valid_reg <= 1'b0;
        end
    end

    // ID/EX payload: captured only on acceptance, never re-forwarded while held
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            pc_reg      <= '0;
            cmd_reg     <= CMD_W'(CMD_NOP);
            rs1_val_reg <= '0;
            rs2_val_reg <= '0;
            imm_reg     <= '0;
            rd_reg      <= '0;
            rd_we_reg   <= 1'b0;
            illegal_reg <= 1'b0;
        end else if (accept) begin
            pc_reg      <= in_pc;
            cmd_reg     <= CMD_W'(dec_cmd);
            rs1_val_reg <= op_val[0];
            rs2_val_reg <= op_val[1];
            imm_reg     <= dec_imm;
            rd_reg      <= dec_rd;
            rd_we_reg   <= dec_rd_we;
            illegal_reg <= dec_illegal;
        end
    end

    // Saturating count of cycles spent stalled on a pending producer
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            stall_cnt_reg <= '0;
        end else if (hazard_stall && (stall_cnt_reg != '1)) begin
            stall_cnt_reg <= stall_cnt_reg + 1'b1;
        end
    end

    assign out_valid   = valid_reg;
    assign out_pc      = pc_reg;
    assign out_cmd     = cmd_reg;
    assign out_rs1_val = rs1_val_reg;
    assign out_rs2_val = rs2_val_reg;
    assign out_imm     = imm_reg;
    assign out_rd      = rd_reg;
    assign out_rd_we   = rd_we_reg;
    assign out_illegal = illegal_reg;
    assign stall_cnt   = stall_cnt_reg;

endmodule
